// File: rtl/td4_pkg.sv
// td4_pkg -- shared definitions for the TD4 4-bit CPU.
//
// Holds the 4-bit opcode constants, the ALU source select encodings,
// the register destination encodings and the instruction decoder used
// by td4_core. No ports; imported with `import td4_pkg::*`.

package td4_pkg;

    // Opcode field values (instruction bits [7:4])
    localparam logic [3:0] OP_ADD_A  = 4'b0000;
    localparam logic [3:0] OP_MOV_AB = 4'b0001;
    localparam logic [3:0] OP_IN_A   = 4'b0010;
    localparam logic [3:0] OP_MOV_A  = 4'b0011;
    localparam logic [3:0] OP_MOV_BA = 4'b0100;
    localparam logic [3:0] OP_ADD_B  = 4'b0101;
    localparam logic [3:0] OP_IN_B   = 4'b0110;
    localparam logic [3:0] OP_MOV_B  = 4'b0111;
    localparam logic [3:0] OP_OUT_B  = 4'b1001;
    localparam logic [3:0] OP_OUT_I  = 4'b1011;
    localparam logic [3:0] OP_JNC    = 4'b1110;
    localparam logic [3:0] OP_JMP    = 4'b1111;

    // First ALU operand; the second operand is always the immediate
    typedef enum logic [1:0] {
        SRC_A    = 2'd0,
        SRC_B    = 2'd1,
        SRC_IN   = 2'd2,
        SRC_ZERO = 2'd3
    } alu_src_e;

    // Register written with the ALU result
    typedef enum logic [1:0] {
        DST_NONE = 2'd0,
        DST_A    = 2'd1,
        DST_B    = 2'd2,
        DST_OUT  = 2'd3
    } dest_e;

    typedef struct packed {
        alu_src_e src;
        dest_e    dst;
        logic     jmp;
        logic     jnc;
    } ctrl_t;

    // Undefined opcodes fall through to the defaults: zero source and no
    // write, so they behave as a NOP that still clears the carry flag.
    // Jumps also use the zero source, which is what makes C drop to 0.
    function automatic ctrl_t decode_op(input logic [3:0] op);
        ctrl_t c;
        c.src = SRC_ZERO;
        c.dst = DST_NONE;
        c.jmp = 1'b0;
        c.jnc = 1'b0;
        case (op)
            OP_ADD_A:  begin c.src = SRC_A;    c.dst = DST_A;   end
            OP_MOV_AB: begin c.src = SRC_B;    c.dst = DST_A;   end
            OP_IN_A:   begin c.src = SRC_IN;   c.dst = DST_A;   end
            OP_MOV_A:  begin c.src = SRC_ZERO; c.dst = DST_A;   end
            OP_MOV_BA: begin c.src = SRC_A;    c.dst = DST_B;   end
            OP_ADD_B:  begin c.src = SRC_B;    c.dst = DST_B;   end
            OP_IN_B:   begin c.src = SRC_IN;   c.dst = DST_B;   end
            OP_MOV_B:  begin c.src = SRC_ZERO; c.dst = DST_B;   end
            OP_OUT_B:  begin c.src = SRC_B;    c.dst = DST_OUT; end
            OP_OUT_I:  begin c.src = SRC_ZERO; c.dst = DST_OUT; end
            OP_JNC:    c.jnc = 1'b1;
            OP_JMP:    c.jmp = 1'b1;
            default:   c.jmp = 1'b0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/td4_alu.sv
// td4_alu -- combinational source mux and 4-bit adder for the TD4 CPU.
//
// Ports:
//   src_sel   in  2  operand select (A, B, input switches or zero)
//   reg_a     in  4  register A
//   reg_b     in  4  register B
//   in_port   in  4  input switches
//   imm       in  4  instruction immediate, always the second operand
//   result    out 4  low four bits of src + imm
//   carry_out out 1  bit 4 of src + imm

module td4_alu
    import td4_pkg::*;
(
    input  alu_src_e   src_sel,
    input  logic [3:0] reg_a,
    input  logic [3:0] reg_b,
    input  logic [3:0] in_port,
    input  logic [3:0] imm,
    output logic [3:0] result,
    output logic       carry_out
);

    logic [3:0] src;
    logic [4:0] sum;

    always_comb begin
        src = 4'd0;
        case (src_sel)
            SRC_A:    src = reg_a;
            SRC_B:    src = reg_b;
            SRC_IN:   src = in_port;
            SRC_ZERO: src = 4'd0;
            default:  src = 4'd0;
        endcase
    end

    assign sum       = {1'b0, src} + {1'b0, imm};
    assign result    = sum[3:0];
    assign carry_out = sum[4];

endmodule

// File: rtl/td4_core.sv
// td4_core -- TD4 4-bit CPU datapath and control.
//
// Fetches from a combinational program ROM addressed by PC and executes
// one instruction per rising clock edge while run is high.
//
// Parameters:
//   HALT_DETECT  1: flag a JMP / taken JNC to its own address; 0: halted stays 0
// Ports:
//   clk       in  1  system clock
//   rst_n     in  1  asynchronous active-low reset
//   run       in  1  execute enable; low holds every register
//   rom_data  in  8  instruction at rom_addr (opcode [7:4], immediate [3:0])
//   in_port   in  4  input switches, sampled on the executing edge
//   rom_addr  out 4  current PC
//   out_port  out 4  OUT register
//   carry     out 1  carry flag C
//   halted    out 1  registered self-loop indicator

module td4_core
    import td4_pkg::*;
#(
    parameter bit HALT_DETECT = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic [7:0] rom_data,
    input  logic [3:0] in_port,
    output logic [3:0] rom_addr,
    output logic [3:0] out_port,
    output logic       carry,
    output logic       halted
);

    logic [3:0] pc;
    logic [3:0] reg_a;
    logic [3:0] reg_b;
    logic [3:0] reg_out;
    logic       reg_c;
    logic       halt_q;

    logic [3:0] opcode;
    logic [3:0] imm;
    ctrl_t      ctrl;
    logic [3:0] alu_result;
    logic       alu_carry;
    logic       jump_taken;
    logic       self_loop;
    logic [3:0] pc_next;

    assign opcode = rom_data[7:4];
    assign imm    = rom_data[3:0];
    assign ctrl   = decode_op(opcode);

    td4_alu u_alu (
        .src_sel   (ctrl.src),
        .reg_a     (reg_a),
        .reg_b     (reg_b),
        .in_port   (in_port),
        .imm       (imm),
        .result    (alu_result),
        .carry_out (alu_carry)
    );

    // JNC looks at the carry left by the previous instruction
    assign jump_taken = ctrl.jmp | (ctrl.jnc & ~reg_c);
    // 4-bit increment wraps 15 -> 0 naturally
    assign pc_next    = jump_taken ? imm : pc + 4'd1;
    assign self_loop  = jump_taken && (imm == pc);

    // Carry is rewritten by every executed instruction, including jumps
    // and NOPs, whose zero-source ALU pass always yields 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc      <= 4'd0;
            reg_a   <= 4'd0;
            reg_b   <= 4'd0;
            reg_out <= 4'd0;
            reg_c   <= 1'b0;
            halt_q  <= 1'b0;
        end else if (run) begin
            pc     <= pc_next;
            reg_c  <= alu_carry;
            halt_q <= HALT_DETECT && self_loop;
            case (ctrl.dst)
                DST_A:   reg_a   <= alu_result;
                DST_B:   reg_b   <= alu_result;
                DST_OUT: reg_out <= alu_result;
                default: reg_a   <= reg_a;
            endcase
        end
    end

    assign rom_addr = pc;
    assign out_port = reg_out;
    assign carry    = reg_c;
    assign halted   = halt_q;

endmodule

// File: tb/tb_td4_core.sv
// tb_td4_core -- scoreboard testbench for td4_core.
//
// Directed instruction vectors are pushed together with their
// hand-computed results (PC after, OUT, C, halted); a monitor process
// pops one expectation after every executed edge and compares.

module tb_td4_core;

    logic       clk;
    logic       rst_n;
    logic       run;
    logic [7:0] rom_data;
    logic [3:0] in_port;
    logic [3:0] rom_addr;
    logic [3:0] out_port;
    logic       carry;
    logic       halted;

    logic [7:0] rom [16];
    logic       use_rom;
    logic [7:0] instr;

    typedef struct {
        string      name;
        logic [3:0] pc;
        logic [3:0] out;
        logic       c;
        logic       h;
    } exp_t;

    exp_t sb[$];
    int   total;
    int   bad;

    td4_core #(.HALT_DETECT(1'b1)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .run      (run),
        .rom_data (rom_data),
        .in_port  (in_port),
        .rom_addr (rom_addr),
        .out_port (out_port),
        .carry    (carry),
        .halted   (halted)
    );

    // Combinational ROM: either the program image or a directly driven vector
    assign rom_data = use_rom ? rom[rom_addr] : instr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [3:0] pc_e,
                               input logic [3:0] out_e, input logic c_e,
                               input logic h_e);
        total++;
        if (rom_addr !== pc_e || out_port !== out_e || carry !== c_e || halted !== h_e) begin
            bad++;
            $display("[TB] FAIL %s: got pc=%h out=%h c=%b halted=%b, want pc=%h out=%h c=%b halted=%b",
                     name, rom_addr, out_port, carry, halted, pc_e, out_e, c_e, h_e);
        end
    endtask

    // Present one instruction for exactly one rising edge and queue its result
    task automatic applyStimulus(input string name, input logic [7:0] instr_v,
                                 input logic [3:0] in_v, input logic [3:0] pc_e,
                                 input logic [3:0] out_e, input logic c_e,
                                 input logic h_e);
        exp_t e;
        @(negedge clk);
        #1;
        instr   = instr_v;
        in_port = in_v;
        run     = 1'b1;
        e.name  = name;
        e.pc    = pc_e;
        e.out   = out_e;
        e.c     = c_e;
        e.h     = h_e;
        sb.push_back(e);
        @(posedge clk);
        #1;
        run = 1'b0;
    endtask

    // Monitor: after every executing edge, compare against the queue head
    initial begin : monitor
        logic fired;
        exp_t e;
        forever begin
            @(posedge clk);
            fired = run && rst_n;
            @(negedge clk);
            if (fired) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected_exec: got pc=%h with no queued expectation", rom_addr);
                end else begin
                    e = sb.pop_front();
                    checkOutput(e.name, e.pc, e.out, e.c, e.h);
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("[TB] FAIL watchdog: got no finish, want finish before time limit");
        $fatal(1, "[TB] timeout");
    end

    initial begin : stimulus
        total   = 0;
        bad     = 0;
        rst_n   = 1'b0;
        run     = 1'b0;
        use_rom = 1'b0;
        instr   = 8'h00;
        in_port = 4'h0;

        // Program image for the full run; unused slots output 1 to expose bad jumps
        for (int i = 0; i < 16; i++) rom[i] = 8'hB1;
        rom[0]  = 8'hB7;
        rom[1]  = 8'hB6;
        rom[2]  = 8'hB0;
        rom[3]  = 8'hB4;
        rom[4]  = 8'h3F;
        rom[5]  = 8'h01;
        rom[6]  = 8'hE6;
        rom[7]  = 8'h78;
        rom[8]  = 8'h90;
        rom[9]  = 8'hEC;
        rom[12] = 8'hFF;
        rom[15] = 8'hFF;

        #12;
        checkOutput("reset_state", 4'h0, 4'h0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Carry out of ADD, then cleared by a MOV
        applyStimulus("mov_a_15",  8'h3F, 4'h0, 4'h1, 4'h0, 1'b0, 1'b0);
        applyStimulus("add_a_1",   8'h01, 4'h0, 4'h2, 4'h0, 1'b1, 1'b0);
        applyStimulus("mov_b_3",   8'h73, 4'h0, 4'h3, 4'h0, 1'b0, 1'b0);

        // run low for 10 clocks: nothing may move despite changing inputs
        @(negedge clk);
        #1;
        instr   = 8'hB5;
        in_port = 4'h9;
        repeat (10) @(negedge clk);
        checkOutput("run_hold", 4'h3, 4'h0, 1'b0, 1'b0);

        // Single-step pulse; B=3+13 overflows to 0 with carry
        applyStimulus("step_add_b", 8'h5D, 4'h0, 4'h4, 4'h0, 1'b1, 1'b0);

        // JNC not taken on C=1, then taken on C=0, then taken onto itself
        applyStimulus("jnc_fall",  8'hE5, 4'h0, 4'h5, 4'h0, 1'b0, 1'b0);
        applyStimulus("jnc_taken", 8'hE1, 4'h0, 4'h1, 4'h0, 1'b0, 1'b0);
        applyStimulus("jnc_self",  8'hE1, 4'h0, 4'h1, 4'h0, 1'b0, 1'b1);

        // IO path; the IN also clears halted
        applyStimulus("in_a",      8'h20, 4'hA, 4'h2, 4'h0, 1'b0, 1'b0);
        applyStimulus("out_imm",   8'hB6, 4'h0, 4'h3, 4'h6, 1'b0, 1'b0);
        applyStimulus("mov_b_a",   8'h40, 4'h0, 4'h4, 4'h6, 1'b0, 1'b0);
        applyStimulus("out_b",     8'h90, 4'h0, 4'h5, 4'hA, 1'b0, 1'b0);

        // MOV B,A with immediate carries (10+15), undefined opcode clears C
        applyStimulus("mov_ba_imm", 8'h4F, 4'h0, 4'h6, 4'hA, 1'b1, 1'b0);
        applyStimulus("undef_nop",  8'h83, 4'h0, 4'h7, 4'hA, 1'b0, 1'b0);
        applyStimulus("out_b_9",    8'h90, 4'h0, 4'h8, 4'h9, 1'b0, 1'b0);
        applyStimulus("in_b_imm",   8'h6A, 4'h7, 4'h9, 4'h9, 1'b1, 1'b0);
        applyStimulus("out_b_1",    8'h90, 4'h0, 4'hA, 4'h1, 1'b0, 1'b0);

        // JMP to 15, then PC wraps to 0
        applyStimulus("jmp_15",    8'hFF, 4'h0, 4'hF, 4'h1, 1'b0, 1'b0);
        applyStimulus("pc_wrap",   8'h50, 4'h0, 4'h0, 4'h1, 1'b0, 1'b0);

        // Build A=5, OUT=3, PC=9 then reset asynchronously
        applyStimulus("mov_a_5",   8'h35, 4'h0, 4'h1, 4'h1, 1'b0, 1'b0);
        applyStimulus("out_3",     8'hB3, 4'h0, 4'h2, 4'h3, 1'b0, 1'b0);
        applyStimulus("jmp_9",     8'hF9, 4'h0, 4'h9, 4'h3, 1'b0, 1'b0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset", 4'h0, 4'h0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;

        // A must read back as 0: B = A+1 = 1
        applyStimulus("a_cleared", 8'h41, 4'h0, 4'h1, 4'h0, 1'b0, 1'b0);
        applyStimulus("out_a_chk", 8'h90, 4'h0, 4'h2, 4'h1, 1'b0, 1'b0);

        // Full program from the ROM image
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        rst_n   = 1'b1;
        use_rom = 1'b1;
        applyStimulus("prog_0",  8'h00, 4'h0, 4'h1, 4'h7, 1'b0, 1'b0);
        applyStimulus("prog_1",  8'h00, 4'h0, 4'h2, 4'h6, 1'b0, 1'b0);
        applyStimulus("prog_2",  8'h00, 4'h0, 4'h3, 4'h0, 1'b0, 1'b0);
        applyStimulus("prog_3",  8'h00, 4'h0, 4'h4, 4'h4, 1'b0, 1'b0);
        applyStimulus("prog_4",  8'h00, 4'h0, 4'h5, 4'h4, 1'b0, 1'b0);
        applyStimulus("prog_5",  8'h00, 4'h0, 4'h6, 4'h4, 1'b1, 1'b0);
        applyStimulus("prog_6",  8'h00, 4'h0, 4'h7, 4'h4, 1'b0, 1'b0);
        applyStimulus("prog_7",  8'h00, 4'h0, 4'h8, 4'h4, 1'b0, 1'b0);
        applyStimulus("prog_8",  8'h00, 4'h0, 4'h9, 4'h8, 1'b0, 1'b0);
        applyStimulus("prog_9",  8'h00, 4'h0, 4'hC, 4'h8, 1'b0, 1'b0);
        applyStimulus("prog_12", 8'h00, 4'h0, 4'hF, 4'h8, 1'b0, 1'b0);
        applyStimulus("prog_15", 8'h00, 4'h0, 4'hF, 4'h8, 1'b0, 1'b1);
        applyStimulus("prog_hlt", 8'h00, 4'h0, 4'hF, 4'h8, 1'b0, 1'b1);

        repeat (2) @(negedge clk);
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("[TB] FAIL drain: got %0d pending expectations, want 0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
